// File: rtl/mmio_uart_fifo_pkg.sv
// mmio_uart_fifo_pkg: shared address map and status bit layout for the MMIO UART block
// Holds the default I/O window base, register offsets within the window,
// and the bit positions of the status word.
package mmio_uart_fifo_pkg;
    localparam logic [31:0] DEF_IO_BASE    = 32'h8000_0000;
    localparam logic [7:0]  OFS_STATUS     = 8'h00;
    localparam logic [7:0]  OFS_RX         = 8'h04;
    localparam logic [7:0]  OFS_TX         = 8'h08;
    localparam logic [7:0]  OFS_CYC        = 8'h10;
    localparam logic [7:0]  OFS_CYC_CLR    = 8'h18;
    localparam int          ST_TX_NOTFULL  = 0;
    localparam int          ST_RX_NONEMPTY = 1;
    localparam int          ST_OVF         = 2;
endpackage

// File: rtl/mmio_uart_fifo_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with simultaneous push/pop
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, din     write request and data; ignored when full unless a pop frees a slot
//   pop           read request; ignored when empty
//   dout          head entry, valid whenever empty is low
//   full, empty   occupancy flags
//   count         number of stored entries (log2(DEPTH)+1 bits)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot a push at full needs
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/mmio_uart_fifo.sv
// mmio_uart_fifo: memory-mapped UART bridge with TX/RX FIFOs, status and cycle counter
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   stall                     freezes CPU-side pushes, pops, counter clear and dout
//   addr, re, we, din         execute-stage load/store request
//   dout                      registered load data, one cycle after re
//   uart_din/_vld/_rdy        TX stream toward the UART transmitter (show-ahead)
//   uart_dout/_vld/_rdy       RX stream from the UART receiver
// Build option: define MMIO_UART_OVF_STICKY_EN for the sticky RX overflow status bit.
module mmio_uart_fifo
    import mmio_uart_fifo_pkg::*;
#(
    parameter int          TX_DEPTH = 8,
    parameter int          RX_DEPTH = 8,
    parameter logic [31:0] IO_BASE  = DEF_IO_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [7:0]  din,
    output logic [31:0] dout,
    output logic [7:0]  uart_din,
    output logic        uart_din_vld,
    input  logic        uart_din_rdy,
    input  logic [7:0]  uart_dout,
    input  logic        uart_dout_vld,
    output logic        uart_dout_rdy
);
    logic                      hit, cpu_rd, cpu_wr;
    logic [7:0]                ofs;
    logic                      tx_push, rx_pop, cyc_clr, st_rd;
    logic                      tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]                rx_head;
    logic [$clog2(TX_DEPTH):0] tx_cnt;
    logic [$clog2(RX_DEPTH):0] rx_cnt;
    logic [31:0]               cyc, status, rd_data;
    logic                      ovf;

    assign hit     = addr[31:28] == IO_BASE[31:28];
    assign ofs     = addr[7:0];
    assign cpu_rd  = re && !stall;
    assign cpu_wr  = we && !stall && hit;
    assign tx_push = cpu_wr && ofs == OFS_TX;
    assign cyc_clr = cpu_wr && ofs == OFS_CYC_CLR;
    assign rx_pop  = cpu_rd && hit && ofs == OFS_RX;
    assign st_rd   = cpu_rd && hit && ofs == OFS_STATUS;

    assign uart_din_vld  = !tx_empty;
    assign uart_dout_rdy = !rx_full;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (uart_din_vld && uart_din_rdy),
        .din   (din),
        .dout  (uart_din),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_cnt)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_dout_vld && uart_dout_rdy),
        .pop   (rx_pop),
        .din   (uart_dout),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_cnt)
    );

`ifdef MMIO_UART_OVF_STICKY_EN
    // an arriving byte that finds RX full outranks a status-read clear
    always_ff @(posedge clk) begin
        if (rst) ovf <= 1'b0;
        else if (uart_dout_vld && rx_full) ovf <= 1'b1;
        else if (st_rd) ovf <= 1'b0;
    end
`else
    assign ovf = 1'b0;
`endif

    always_comb begin
        status                 = '0;
        status[ST_TX_NOTFULL]  = !tx_full;
        status[ST_RX_NONEMPTY] = !rx_empty;
        status[ST_OVF]         = ovf;
    end

    // stale RX storage must never leak out when the FIFO is empty
    assign rd_data = !hit                ? 32'h0 :
                     ofs == OFS_STATUS   ? status :
                     ofs == OFS_RX       ? {24'h0, rx_empty ? 8'h0 : rx_head} :
                     ofs == OFS_CYC      ? cyc : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) dout <= '0;
        else if (cpu_rd) dout <= rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst || cyc_clr) cyc <= '0;
        else cyc <= cyc + 32'd1;
    end
endmodule
